// File: rtl/hearts_pkg.sv
// Shared types and constants for the hearts/lives controller.
// The optional blink/invulnerability feature is selected by HEARTS_INVULN_BLINK_EN.
package hearts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIVE = 2'd1,
    BLINK = 2'd2,
    OVER  = 2'd3
  } hearts_state_t;

  localparam int DEFAULT_NUM_HEARTS = 3;

  // Width needed to hold a lives count from 0 up to num_hearts inclusive.
  function automatic int lives_w(input int num_hearts);
    return $clog2(num_hearts + 1);
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts startOfFrame pulses modulo BLINK_FRAMES and flags the pulse that
// completes a period. Only present when HEARTS_INVULN_BLINK_EN is defined,
// because nothing else in the design needs frame timing.
`ifdef HEARTS_INVULN_BLINK_EN
module frame_tick_counter #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_start_of_frame,
  output logic o_tick
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_frame_cnt;
  logic             w_frame_ev;

  assign w_frame_ev = i_enable & i_start_of_frame;
  // Tick is combinational so the owner can act on the same edge that wraps the count.
  assign o_tick     = w_frame_ev & (r_frame_cnt == C_LAST);

  // Frame counter: clear wins, otherwise advance and wrap on each enabled frame pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_cnt <= CNT_W'(0);
    end else if (i_clear) begin
      r_frame_cnt <= CNT_W'(0);
    end else if (w_frame_ev) begin
      if (r_frame_cnt == C_LAST) begin
        r_frame_cnt <= CNT_W'(0);
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

endmodule
`endif

// File: rtl/hearts_lives_ctrl.sv
// Lives tracker and heart-icon visibility mask for the hearts priority mux.
// Optional macro HEARTS_INVULN_BLINK_EN: when defined, a non-fatal hit blinks
// the lost heart and ignores further hits until the blink episode ends; when
// undefined, the lost heart disappears at once and hits are always accepted.
module hearts_lives_ctrl
  import hearts_pkg::*;
#(
  parameter int NUM_HEARTS    = DEFAULT_NUM_HEARTS,
  parameter int INIT_LIVES    = 3,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start_of_frame,
  input  logic                           i_game_start,
  input  logic                           i_hit_pulse,
  input  logic                           i_bonus_pulse,
  input  logic [NUM_HEARTS-1:0]          i_hearts_raw_request,
  output logic [NUM_HEARTS-1:0]          o_hearts_bus_request,
  output logic [lives_w(NUM_HEARTS)-1:0] o_lives,
  output logic                           o_game_over,
  output logic                           o_life_lost
);

  localparam int LIVES_W = lives_w(NUM_HEARTS);
  localparam logic [LIVES_W-1:0] C_MAX  = LIVES_W'(NUM_HEARTS);
  localparam logic [LIVES_W-1:0] C_INIT = LIVES_W'(INIT_LIVES);

  hearts_state_t         r_state, w_state_nxt;
  logic [LIVES_W-1:0]    r_lives, w_lives_nxt;
  logic [LIVES_W-1:0]    w_lives_inc, w_lives_dec;
  logic [NUM_HEARTS-1:0] r_vis_mask, w_vis_mask_nxt;
  logic                  r_game_over, w_game_over_nxt;
  logic                  r_life_lost, w_life_lost_nxt;
  logic                  w_hit_only, w_bonus_only;

  // A simultaneous hit and bonus cancel each other.
  assign w_hit_only   = i_hit_pulse & ~i_bonus_pulse;
  assign w_bonus_only = i_bonus_pulse & ~i_hit_pulse;
  assign w_lives_inc  = (r_lives >= C_MAX) ? r_lives : r_lives + LIVES_W'(1);
  assign w_lives_dec  = (r_lives == LIVES_W'(0)) ? r_lives : r_lives - LIVES_W'(1);

`ifdef HEARTS_INVULN_BLINK_EN
  localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);

  logic [TOG_W-1:0] r_toggle_cnt, w_toggle_nxt;
  logic             r_blink_phase, w_phase_nxt;
  logic             w_frame_tick, w_frame_clr, w_frame_en;

  // The frame counter only runs while blinking; any way out of BLINK restarts it.
  assign w_frame_en  = (r_state == BLINK);
  assign w_frame_clr = (r_state != BLINK) | i_game_start | i_bonus_pulse;

  frame_tick_counter #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_tick (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_clear          (w_frame_clr),
    .i_enable         (w_frame_en),
    .i_start_of_frame (i_start_of_frame),
    .o_tick           (w_frame_tick)
  );
`else
  logic w_unused_sof;
  assign w_unused_sof = i_start_of_frame;
`endif

  // State register together with the lives and blink datapath.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_lives       <= LIVES_W'(0);
`ifdef HEARTS_INVULN_BLINK_EN
      r_toggle_cnt  <= TOG_W'(0);
      r_blink_phase <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
`ifdef HEARTS_INVULN_BLINK_EN
      r_toggle_cnt  <= w_toggle_nxt;
      r_blink_phase <= w_phase_nxt;
`endif
    end
  end

  // Next-state decision: gameStart first, then per-state hit/bonus/frame handling.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
`ifdef HEARTS_INVULN_BLINK_EN
    w_toggle_nxt = r_toggle_cnt;
    w_phase_nxt  = r_blink_phase;
`endif
    if (i_game_start) begin
      w_state_nxt = ALIVE;
      w_lives_nxt = C_INIT;
`ifdef HEARTS_INVULN_BLINK_EN
      w_toggle_nxt = TOG_W'(0);
      w_phase_nxt  = 1'b0;
`endif
    end else begin
      case (r_state)
        ALIVE: begin
          if (w_hit_only) begin
            w_lives_nxt = w_lives_dec;
            if (w_lives_dec == LIVES_W'(0)) begin
              w_state_nxt = OVER;
            end else begin
`ifdef HEARTS_INVULN_BLINK_EN
              w_state_nxt  = BLINK;
              w_toggle_nxt = TOG_W'(0);
              w_phase_nxt  = 1'b1;
`else
              w_state_nxt  = ALIVE;
`endif
            end
          end else if (w_bonus_only) begin
            w_lives_nxt = w_lives_inc;
          end else begin
            w_lives_nxt = r_lives;
          end
        end
`ifdef HEARTS_INVULN_BLINK_EN
        BLINK: begin
          if (i_bonus_pulse) begin
            // Bonus restores the blinking heart and ends invulnerability.
            w_lives_nxt  = w_lives_inc;
            w_state_nxt  = ALIVE;
            w_toggle_nxt = TOG_W'(0);
            w_phase_nxt  = 1'b0;
          end else if (w_frame_tick) begin
            if (r_toggle_cnt == TOG_W'(BLINK_TOGGLES - 1)) begin
              w_state_nxt  = ALIVE;
              w_toggle_nxt = TOG_W'(0);
              w_phase_nxt  = 1'b0;
            end else begin
              w_toggle_nxt = r_toggle_cnt + TOG_W'(1);
              w_phase_nxt  = ~r_blink_phase;
            end
          end else begin
            w_state_nxt = BLINK;
          end
        end
`endif
        IDLE, OVER: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so mask, lives and gameOver change together.
  always_comb begin
    w_life_lost_nxt = ~i_game_start & (r_state == ALIVE) & w_hit_only;
    w_game_over_nxt = (w_state_nxt == OVER);
    w_vis_mask_nxt  = {NUM_HEARTS{1'b0}};
    for (int i = 0; i < NUM_HEARTS; i++) begin
`ifdef HEARTS_INVULN_BLINK_EN
      w_vis_mask_nxt[i] = (i < int'(w_lives_nxt)) ||
                          ((w_state_nxt == BLINK) && (i == int'(w_lives_nxt)) && w_phase_nxt);
`else
      w_vis_mask_nxt[i] = (i < int'(w_lives_nxt));
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vis_mask  <= {NUM_HEARTS{1'b0}};
      r_game_over <= 1'b0;
      r_life_lost <= 1'b0;
    end else begin
      r_vis_mask  <= w_vis_mask_nxt;
      r_game_over <= w_game_over_nxt;
      r_life_lost <= w_life_lost_nxt;
    end
  end

  // Masking stays combinational so pixel alignment into the mux is untouched.
  assign o_hearts_bus_request = i_hearts_raw_request & r_vis_mask;
  assign o_lives              = r_lives;
  assign o_game_over          = r_game_over;
  assign o_life_lost          = r_life_lost;

endmodule

// File: doc/hearts_lives_ctrl.md
Name: hearts_lives_ctrl

Overview:
Tracks the player's remaining lives and decides which heart icons are visible on each frame. Masks the raw per-heart drawing requests from the heart bitmap objects and drives the masked vector into the hearts priority mux downstream. On a life loss, blinks the lost heart for a fixed number of frames; during that window further hits are ignored (invulnerability). Asserts game-over when lives reach zero.

Parameters:
NUM_HEARTS, 3, number of heart icons and maximum lives
INIT_LIVES, 3, lives loaded on gameStart; must be 1..NUM_HEARTS
BLINK_FRAMES, 8, frames per blink half-period
BLINK_TOGGLES, 6, phase toggles per blink episode; even value ends with the heart hidden

Ports:
clk  in  1  system clock (pixel clock domain)
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-clk pulse per video frame
gameStart  in  1  one-clk pulse; reload lives
hitPulse  in  1  one-clk pulse; player hit
bonusPulse  in  1  one-clk pulse; extra life
heartsRawRequest  in  NUM_HEARTS  per-heart drawing request from the heart objects
heartsBusRequest  out  NUM_HEARTS  masked requests to the hearts mux
lives  out  LIVES_W  current lives, where LIVES_W = $clog2(NUM_HEARTS+1)
gameOver  out  1  level; high in OVER state
lifeLost  out  1  one-clk pulse on each accepted hit

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values: state IDLE, lives=0, blink counters=0, blinkPhase=0, visMask=0, gameOver=0, lifeLost=0. Because visMask=0, heartsBusRequest=0.
- FSM states: IDLE, ALIVE, BLINK, OVER.
- gameStart has priority over all other events in every state. It moves the FSM to ALIVE, sets lives=INIT_LIVES, and clears the blink counters.
- IDLE and OVER ignore hitPulse and bonusPulse.
- ALIVE, hitPulse alone:
  - lives decrements by 1 and lifeLost pulses on the next clk.
  - If the new lives value is 0, go to OVER.
  - Otherwise go to BLINK with frameCnt=0, toggleCnt=0, blinkPhase=1.
- ALIVE, bonusPulse alone: lives increments, saturating at NUM_HEARTS.
- ALIVE, hitPulse and bonusPulse in the same cycle: the events cancel. No change to lives and no lifeLost pulse.
- BLINK:
  - hitPulse is ignored.
  - On each startOfFrame, frameCnt increments. When frameCnt reaches BLINK_FRAMES-1, frameCnt resets to 0, blinkPhase toggles, and toggleCnt increments.
  - When toggleCnt reaches BLINK_TOGGLES, go to ALIVE.
  - bonusPulse increments lives (restoring the blinking heart) and goes to ALIVE immediately.
- gameOver = (state==OVER), registered.
- Visibility:
  - visMask[i] is registered and updates every clk.
  - visMask[i] = (i < lives) || (state==BLINK && i==lives && blinkPhase).
- heartsBusRequest = heartsRawRequest & visMask, combinational with zero latency, so pixel alignment is preserved into the registered mux.
- A reset asserted mid-BLINK or in any other state returns to the reset values immediately (asynchronous).
- Width rule: lives never underflows below 0 and never exceeds NUM_HEARTS.

Optional Feature:
HEARTS_INVULN_BLINK_EN
- Defined: BLINK state as described above.
- Undefined: the BLINK state and its counters are not compiled. A non-fatal hit returns directly to ALIVE, with no invulnerability, and the lost heart disappears on the next clk.

Decomposition:
- Package hearts_pkg holds:
  - the state enum type hearts_state_t {IDLE, ALIVE, BLINK, OVER};
  - the default NUM_HEARTS;
  - the LIVES_W function/constant.
- One sub-module: frame_tick_counter. It counts startOfFrame pulses modulo BLINK_FRAMES and emits a period tick. It has clear and enable inputs and is instantiated only under HEARTS_INVULN_BLINK_EN.

Test Plan (BLINK_FRAMES=2, BLINK_TOGGLES=4, macro defined unless noted):
- Reset, then gameStart, then heartsRawRequest=3'b111 -> lives=3, heartsBusRequest=3'b111, gameOver=0.
- hitPulse in ALIVE with lives=3 -> lifeLost pulses once, lives=2, and heartsBusRequest[2] follows blinkPhase. It shows on frames 0-1, hides on 2-3, shows on 4-5, and hides on 6-7. After frame 8 the FSM is in ALIVE with mask 3'b011.
- hitPulse during BLINK -> ignored; lives stays 2 and lifeLost=0.
- From lives=1, hitPulse -> lives=0, gameOver=1, heartsBusRequest=0. A following bonusPulse is ignored; gameStart restores lives=3 and gameOver=0.
- hitPulse and bonusPulse in the same cycle in ALIVE with lives=2 -> lives=2 and no lifeLost. bonusPulse at lives=3 -> stays at 3.
- Macro undefined: hitPulse at lives=3 -> mask 3'b011 on the next clk and the FSM is in ALIVE. A second hitPulse one cycle later is accepted, giving lives=1.
